load_calc_sequencer: RTL

- Parametrised successor to the single-frame load/calc controller: sequences a multi-beat LOAD phase, a fixed-length CALC phase, and a FLUSH/recovery phase.
- Adds beat counting, bounded retry on load error, overflow abort, and done/status reporting.
- Sits between the operand-fetch handshake (start/ready) and the datapath enables (load, calc_en, flush).

---
 rtl/load_calc_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/load_calc_sequencer.sv
// Frame sequencer: multi-beat LOAD, fixed-length CALC, one-cycle FLUSH recovery
// with bounded retry on load error and abort on datapath overflow.
module load_calc_sequencer #(
   parameter int LOAD_BEATS  = 4,
   parameter int CALC_CYCLES = 2,
   parameter int MAX_RETRY   = 1,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ready,
   input  logic             error,
   input  logic             ov_flag,
   output logic             load,
   output logic             calc_en,
   output logic             flush,
   output logic             controller_inuse,
   output logic             done,
   output logic [CNT_W-1:0] beat_idx,
   output logic [1:0]       status,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CALC  = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [1:0]       ST_OK      = 2'b00;
   localparam logic [1:0]       ST_RETRIED = 2'b01;
   localparam logic [1:0]       ST_OVF     = 2'b10;
   localparam logic [1:0]       ST_FAIL    = 2'b11;
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LOAD_BEATS - 1);
   localparam logic [CNT_W-1:0] LAST_CALC  = CNT_W'(CALC_CYCLES - 1);
   localparam logic [2:0]       RETRY_LIM  = 3'(MAX_RETRY);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] calc_q, calc_d;
   logic [2:0]       retry_q, retry_d;
   logic             cause_ovf_q, cause_ovf_d;
   logic [1:0]       status_q, status_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         calc_q      <= '0;
         retry_q     <= '0;
         cause_ovf_q <= 1'b0;
         status_q    <= ST_OK;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         calc_q      <= calc_d;
         retry_q     <= retry_d;
         cause_ovf_q <= cause_ovf_d;
         status_q    <= status_d;
      end
   end

   // Beat handshake: ready is the upstream valid; a beat transfers (load=1) in any
   // LOAD cycle with ready=1 and error=0. error wins over ready and aborts the frame.
   always_comb begin
      state_d          = state_q;
      beat_d           = beat_q;
      calc_d           = calc_q;
      retry_d          = retry_q;
      cause_ovf_d      = cause_ovf_q;
      status_d         = status_q;
      load             = 1'b0;
      calc_en          = 1'b0;
      flush            = 1'b0;
      done             = 1'b0;
      controller_inuse = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_LOAD;
               beat_d   = '0;
               calc_d   = '0;
               retry_d  = '0;
               status_d = ST_OK;
            end
         end
         S_LOAD: begin
            if (error) begin
               state_d     = S_FLUSH;
               cause_ovf_d = 1'b0;
            end else if (ready) begin
               load = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  calc_d  = '0;
                  state_d = S_CALC;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end
         end
         S_CALC: begin
            calc_en = 1'b1;
            if (ov_flag) begin
               state_d     = S_FLUSH;
               cause_ovf_d = 1'b1;
            end else if (calc_q == LAST_CALC) begin
               calc_d  = '0;
               state_d = S_DONE;
            end else begin
               calc_d = calc_q + CNT_W'(1);
            end
         end
         S_FLUSH: begin
            flush  = 1'b1;
            beat_d = '0;
            calc_d = '0;
            // Overflow is a datapath fault, so only load errors earn a reload.
            if (cause_ovf_q) begin
               status_d = ST_OVF;
               state_d  = S_IDLE;
            end else if (retry_q < RETRY_LIM) begin
               retry_d  = retry_q + 3'd1;
               status_d = ST_RETRIED;
               state_d  = S_LOAD;
            end else begin
               status_d = ST_FAIL;
               state_d  = S_IDLE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign beat_idx  = beat_q;
   assign status    = status_q;
   assign dbg_state = state_q;

   a_enables_exclusive: assert property (@(posedge clk) disable iff (rst)
      $onehot0({load, calc_en, flush}));

endmodule
